// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: received-byte valid/ready bus (master = receiver, slave = consumer)
interface uart_rx_ctrl_if;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver; ports clk, rstn (sync active-low), rx_pin_in (async line), bus (rx_data/rx_valid/rx_ready), frame_err/overrun pulses, busy
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int HALF_BIT = CLKS_PER_BIT / 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic rx_pin_in,
  uart_rx_ctrl_if.master bus,
  output logic frame_err,
  output logic overrun,
  output logic busy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic s1, s2, h2l, half_hit, full_hit, clr, load_bit, good, bad;
  logic [BW-1:0] bcnt;
  logic [2:0] bidx;
  logic [7:0] shift;
  assign h2l = s2 & ~s1;
  assign half_hit = bcnt == BW'(HALF_BIT - 1);
  assign full_hit = bcnt == BW'(CLKS_PER_BIT - 1);
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = h2l ? START : IDLE;
      START:   state_n = half_hit ? (s1 ? IDLE : DATA) : START;
      DATA:    state_n = (full_hit && bidx == 3'd7) ? STOP : DATA;
      default: state_n = full_hit ? IDLE : STOP;
    endcase
    load_bit = state == DATA && full_hit;
    good = state == STOP && full_hit && s1;
    bad = state == STOP && full_hit && !s1;
    clr = state_n != state || load_bit;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      s1 <= 1'b1;
      s2 <= 1'b1;
      bcnt <= '0;
      bidx <= '0;
      shift <= '0;
      bus.rx_data <= '0;
      bus.rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      s1 <= rx_pin_in;
      s2 <= s1;
      state <= state_n;
      bcnt <= clr ? '0 : bcnt + 1'b1;
      bidx <= state != DATA ? '0 : bidx + {2'b00, load_bit};
      if (load_bit) shift[bidx] <= s1;
      frame_err <= bad;
      overrun <= good && bus.rx_valid && !bus.rx_ready;
      if (good && (!bus.rx_valid || bus.rx_ready)) bus.rx_data <= shift;
      bus.rx_valid <= good ? 1'b1 : bus.rx_valid & ~bus.rx_ready;
    end
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that sequences start-bit detection, baud-timed mid-bit sampling, byte assembly and stop-bit checking for an 8N1 serial line. It contains its own two-flop input synchronizer and high-to-low start detector, and it drives the baud counter. It hands each received byte to downstream logic over a valid/ready handshake. It sits between the board `rx_pin_in` pad and the byte-consuming logic (command parser / FIFO).

## Interface
Parameters:
- `CLKS_PER_BIT`, 5208: clock cycles per bit period (50 MHz / 9600 baud); legal range ≥ 4.
- `HALF_BIT`, `CLKS_PER_BIT/2`: cycles from start-edge detect to the start-bit mid-sample (integer division).

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `rx_pin_in`  in  1  asynchronous serial line, idle high.
- `rx_data`  out  8  received byte, LSB = first data bit; stable while `rx_valid` = 1.
- `rx_valid`  out  1  byte available; held until accepted.
- `rx_ready`  in  1  consumer accepts the byte when `rx_valid` & `rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a byte completed while the previous byte was still unaccepted.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Synchronizer: `s1 <= rx_pin_in`, `s2 <= s1`. Start detect `h2l = s2 & ~s1`. Both flops reset to 1.
- Baud counter `bcnt`, width ceil(log2(CLKS_PER_BIT)). It clears on every state entry and increments each cycle.
- Bit counter `bidx` covers 0..7.
- FSM states:
  - IDLE: on `h2l`, clear `bcnt` and go to START.
  - START: when `bcnt == HALF_BIT-1`, sample `s1`.
    - If `s1` = 1, treat it as a glitch and return to IDLE with no output.
    - If `s1` = 0, clear `bcnt` and `bidx`, then go to DATA.
  - DATA: when `bcnt == CLKS_PER_BIT-1`, sample `s1` into `shift[bidx]` (LSB first) and clear `bcnt`.
    - If `bidx == 7`, go to STOP; otherwise increment `bidx`.
  - STOP: when `bcnt == CLKS_PER_BIT-1`, sample `s1`.
    - If `s1` = 1, the frame is good: deliver it (see below).
    - If `s1` = 0, pulse `frame_err` and discard the byte.
    - Either way, return to IDLE.
- Delivery of a good frame:
  - If `rx_valid` = 0, or `rx_valid` & `rx_ready` in the same cycle, load `rx_data <= shift` and set `rx_valid` = 1.
  - If `rx_valid` = 1 and `rx_ready` = 0, keep the old byte, drop the new one and pulse `overrun`.
- Handshake: `rx_valid` clears the cycle after `rx_valid` & `rx_ready`, unless a new byte loads in that same cycle, in which case `rx_valid` stays 1.
- Break condition (line held low): it produces a frame of 0x00 with `frame_err`. The FSM then waits in IDLE for a fresh falling edge, because `h2l` needs the line to go high first.
- Reset is synchronous and takes priority everywhere, including mid-frame. It aborts the frame and returns to IDLE.

## Timing
- Reset values: `rx_data` = 8'h00, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0. FSM is IDLE, `bcnt` = 0, `bidx` = 0, `s1` = `s2` = 1.
- Let T0 be the rising edge at which `h2l` = 1 and the FSM is in IDLE. T0 is 2 clocks after the pin falls.
- START sample occurs at T0 + HALF_BIT.
- Data bit i (i = 0..7) is sampled at T0 + HALF_BIT + (i+1)·CLKS_PER_BIT.
- Stop bit is sampled at T0 + HALF_BIT + 9·CLKS_PER_BIT. `rx_valid` / `frame_err` / `overrun` become visible on the following cycle.
- `busy` rises the cycle after T0. It falls the cycle after the stop sample (or after a glitch reject).
- Back-to-back frames: IDLE is re-entered about half a bit before the next start edge, so 0 idle bits between frames are supported.
- `rx_data` and `rx_valid` are registered outputs. `frame_err` and `overrun` are registered single-cycle pulses.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16.
- Reset: hold `rstn` = 0 for 3 cycles while `rx_pin_in` toggles → all outputs are 0 and `busy` = 0. Release reset with the line high → no activity.
- Single frame 0xA5, `rx_ready` = 1: `rx_valid` pulses for 1 cycle with `rx_data` = 8'hA5 at T0 + 8 + 144 + 1, and `frame_err` = 0.
- Glitch: line low for 5 cycles then high → `busy` is high for 8 cycles, then returns to IDLE with no `rx_valid` and no `frame_err`.
- Frame error: send 0x3C with the stop bit driven low → `frame_err` pulses once, `rx_valid` stays 0, and `rx_data` is unchanged.
- Overrun: send 0x11 then 0x22 back-to-back with `rx_ready` = 0 → `rx_data` stays 0x11, `rx_valid` stays 1 and `overrun` pulses once. Raising `rx_ready` for 1 cycle then clears `rx_valid`.
- Simultaneous accept/load, plus reset mid-frame:
  - Assert `rx_ready` exactly in the cycle the second byte 0x22 completes → `rx_valid` stays 1, `rx_data` becomes 0x22, no `overrun`.
  - Assert `rstn` = 0 during bit 4 of a frame → IDLE next cycle, and no output for that frame.
